// File: rtl/draw_pkg.sv
// Shared types and widths for the board drawing controller.
package draw_pkg;

    localparam int POS_W  = 11;
    localparam int SIZE_W = 7;
    localparam int IDX_W  = 5;
    localparam int ACC_W  = POS_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_NEXT = 3'd4,
        ST_DONE = 3'd5
    } draw_state_e;

    // Origin = base + idx*size, formed one bit wider and wrapped to POS_W.
    function automatic logic [POS_W-1:0] cell_origin(
        input logic [POS_W-1:0]  base,
        input logic [IDX_W-1:0]  idx,
        input logic [SIZE_W-1:0] size
    );
        logic [ACC_W-1:0] sum;
        sum = ACC_W'(base) + (ACC_W'(idx) * ACC_W'(size));
        return sum[POS_W-1:0];
    endfunction

endpackage

// File: rtl/game_set_if.sv
// Game settings bundle consumed by the board drawing controller.
interface game_set_if;
    import draw_pkg::*;

    logic [IDX_W-1:0]  button_num;
    logic [SIZE_W-1:0] button_size;
    logic [POS_W-1:0]  board_xpos;
    logic [POS_W-1:0]  board_ypos;

    modport in  (input  button_num, button_size, board_xpos, board_ypos);
    modport out (output button_num, button_size, board_xpos, board_ypos);
endinterface

// File: rtl/cell_index_ctr.sv
// Row-major col/row counter over a max x max grid of cells.
module cell_index_ctr
    import draw_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    input  logic [IDX_W-1:0] max,
    output logic [IDX_W-1:0] col,
    output logic [IDX_W-1:0] row,
    output logic             last
);

    logic [IDX_W-1:0] col_r;
    logic [IDX_W-1:0] row_r;
    logic             col_wrap_s;

    assign col_wrap_s = (col_r == (max - IDX_W'(1'b1)));
    assign last       = col_wrap_s && (row_r == (max - IDX_W'(1'b1)));
    assign col        = col_r;
    assign row        = row_r;

    // Cell index register: clear on load, advance column first then row.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col_r <= IDX_W'(1'b0);
            row_r <= IDX_W'(1'b0);
        end else if (inc) begin
            if (col_wrap_s) begin
                col_r <= IDX_W'(1'b0);
                row_r <= row_r + IDX_W'(1'b1);
            end else begin
                col_r <= col_r + IDX_W'(1'b1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

endmodule

// File: rtl/board_draw_ctrl.sv
// Sweeps every board cell and hands each origin to the button engine.
// Optional watchdog in WAIT: define BOARD_DRAW_TIMEOUT_EN.
module board_draw_ctrl
    import draw_pkg::*;
#(
    parameter int MAX_BUTTONS    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    game_set_if.in            gin,
    input  logic              draw_ack,
    output logic              draw_req,
    output logic [POS_W-1:0]  button_xpos,
    output logic [POS_W-1:0]  button_ypos,
    output logic [SIZE_W-1:0] button_size,
    output logic [IDX_W-1:0]  cell_col,
    output logic [IDX_W-1:0]  cell_row,
    output logic              busy,
    output logic              frame_done
`ifdef BOARD_DRAW_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    draw_state_e state_r, state_nx, fsm_nx_s;

    logic [IDX_W-1:0]  num_r, num_in_s;
    logic [SIZE_W-1:0] size_r;
    logic [POS_W-1:0]  bx_r, by_r;
    logic              inc_s, clear_s, last_s, timeout_s;

    assign num_in_s = (gin.button_num > IDX_W'(MAX_BUTTONS)) ? IDX_W'(MAX_BUTTONS)
                                                             : gin.button_num;
    assign clear_s  = (state_r == ST_LOAD);

    cell_index_ctr u_idx (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_s),
        .inc   (inc_s),
        .max   (num_r),
        .col   (cell_col),
        .row   (cell_row),
        .last  (last_s)
    );

`ifdef BOARD_DRAW_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_r;

    assign timeout_s = (state_r == ST_WAIT) && !draw_ack &&
                       (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts WAIT cycles, restarts on every fresh WAIT entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= WD_W'(1'b0);
        end else if ((state_r == ST_WAIT) && (state_nx == ST_WAIT)) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1'b1);
        end else begin
            wd_cnt_r <= WD_W'(1'b0);
        end
    end

    // Sticky skip flag, cleared when a new sweep is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (state_nx == ST_LOAD) begin
            timeout_err <= 1'b0;
        end else if (timeout_s && !abort) begin
            timeout_err <= 1'b1;
        end else begin
            timeout_err <= timeout_err;
        end
    end
`else
    assign timeout_s = 1'b0;
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
    end
`endif

    // Next-state logic; abort overrides every transition.
    always_comb begin
        fsm_nx_s = state_r;
        inc_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) fsm_nx_s = ST_LOAD;
                else       fsm_nx_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (num_in_s == IDX_W'(1'b0)) fsm_nx_s = ST_DONE;
                else                          fsm_nx_s = ST_REQ;
            end
            ST_REQ:  fsm_nx_s = ST_WAIT;
            ST_WAIT: begin
                if (draw_ack || timeout_s) fsm_nx_s = ST_NEXT;
                else                       fsm_nx_s = ST_WAIT;
            end
            ST_NEXT: begin
                if (last_s) begin
                    fsm_nx_s = ST_DONE;
                end else begin
                    fsm_nx_s = ST_REQ;
                    inc_s    = !abort;
                end
            end
            ST_DONE: fsm_nx_s = ST_IDLE;
            default: fsm_nx_s = ST_IDLE;
        endcase
        if (abort) state_nx = ST_IDLE;
        else       state_nx = fsm_nx_s;
    end

    // Settings snapshot so mid-sweep gin changes cannot disturb the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_r  <= IDX_W'(1'b0);
            size_r <= SIZE_W'(1'b0);
            bx_r   <= POS_W'(1'b0);
            by_r   <= POS_W'(1'b0);
        end else if (state_r == ST_LOAD) begin
            num_r  <= num_in_s;
            size_r <= gin.button_size;
            bx_r   <= gin.board_xpos;
            by_r   <= gin.board_ypos;
        end else begin
            num_r  <= num_r;
            size_r <= size_r;
            bx_r   <= bx_r;
            by_r   <= by_r;
        end
    end

    // State and status outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            draw_req   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_nx;
            draw_req   <= (state_nx == ST_WAIT);
            busy       <= (state_nx != ST_IDLE);
            frame_done <= (state_nx == ST_DONE);
        end
    end

    // Cell geometry is latched in REQ and held through WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            button_xpos <= POS_W'(1'b0);
            button_ypos <= POS_W'(1'b0);
            button_size <= SIZE_W'(1'b0);
        end else if (state_r == ST_REQ) begin
            button_xpos <= cell_origin(bx_r, cell_col, size_r);
            button_ypos <= cell_origin(by_r, cell_row, size_r);
            button_size <= size_r;
        end else begin
            button_xpos <= button_xpos;
            button_ypos <= button_ypos;
            button_size <= button_size;
        end
    end

endmodule

// File: tb/tb_board_draw_ctrl.sv
// Scoreboard bench for board_draw_ctrl: directed sweeps, abort, reset and watchdog.
module tb_board_draw_ctrl;
    import draw_pkg::*;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, draw_ack = 1'b0;
    logic draw_req, busy, frame_done;
    logic [POS_W-1:0]  button_xpos, button_ypos;
    logic [SIZE_W-1:0] button_size;
    logic [IDX_W-1:0]  cell_col, cell_row;
`ifdef BOARD_DRAW_TIMEOUT_EN
    logic timeout_err;
`endif

    game_set_if gs();

    board_draw_ctrl #(.MAX_BUTTONS(16), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gin(gs),
        .draw_ack(draw_ack), .draw_req(draw_req),
        .button_xpos(button_xpos), .button_ypos(button_ypos),
        .button_size(button_size), .cell_col(cell_col), .cell_row(cell_row),
        .busy(busy), .frame_done(frame_done)
`ifdef BOARD_DRAW_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; int col; int row; int size; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   exp_frames = 0;
    int   n_checks = 0, n_fail = 0;
    int   rq_seen = 0, acks_given = 0, ack_limit = 0;
    logic req_prev = 1'b0, frame_prev = 1'b0, req_hold = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every new request and every frame_done is matched against the scoreboard.
    always @(negedge clk) begin
        if (draw_req && !req_prev) begin
            rq_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("req_xpos", int'(button_xpos), mon_e.x);
                chk("req_ypos", int'(button_ypos), mon_e.y);
                chk("req_col",  int'(cell_col),    mon_e.col);
                chk("req_row",  int'(cell_row),    mon_e.row);
                chk("req_size", int'(button_size), mon_e.size);
            end
        end
        if (frame_done) begin
            chk("frame_done_width", int'(frame_prev), 0);
            if (exp_frames == 0) chk("unexpected_frame_done", 1, 0);
            else exp_frames--;
        end
        req_prev   = draw_req;
        frame_prev = frame_done;
    end

    // Button engine model: acks once the request has been visible for a cycle.
    always @(negedge clk) begin
        if (draw_req && req_hold && !draw_ack && (acks_given < ack_limit)) begin
            draw_ack = 1'b1;
            acks_given++;
        end else begin
            draw_ack = 1'b0;
        end
        req_hold = draw_req;
    end

    task automatic push(input int x, input int y, input int c, input int r, input int s);
        exp_t e;
        e.x = x; e.y = y; e.col = c; e.row = r; e.size = s;
        exp_q.push_back(e);
    endtask

    task automatic set_gin(input int n, input int s, input int x, input int y);
        gs.button_num  = IDX_W'(n);
        gs.button_size = SIZE_W'(s);
        gs.board_xpos  = POS_W'(x);
        gs.board_ypos  = POS_W'(y);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_req(input int target, input int budget);
        for (int i = 0; i < budget && rq_seen < target; i++) begin
            @(negedge clk); #1;
        end
        chk("wait_req_bound", int'(rq_seen >= target), 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) begin
            @(negedge clk); #1;
        end
        chk("wait_idle_bound", int'(busy), 0);
    endtask

    initial begin
        int base;
        int hi;
        set_gin(2, 20, 100, 50);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_draw_req", int'(draw_req), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_frame_done", int'(frame_done), 0);
        chk("reset_xpos", int'(button_xpos), 0);

        // 2x2 board, engine acks every cell
        ack_limit = acks_given + 100;
        push(100, 50, 0, 0, 20); push(120, 50, 1, 0, 20);
        push(100, 70, 0, 1, 20); push(120, 70, 1, 1, 20);
        exp_frames++;
        pulse_start();
        chk("busy_after_start", int'(busy), 1);
        @(posedge clk); #1;
        chk("req_latency_2", int'(draw_req), 0);
        @(posedge clk); #1;
        chk("req_latency_3", int'(draw_req), 1);
        wait_idle(200);
        chk("t1_queue_empty", exp_q.size(), 0);
        chk("t1_frames", exp_frames, 0);

        // zero buttons: straight to DONE
        set_gin(0, 20, 100, 50);
        exp_frames++;
        pulse_start();
        @(posedge clk); #1;
        chk("zero_frame_done", int'(frame_done), 1);
        @(posedge clk); #1;
        chk("zero_frame_done_end", int'(frame_done), 0);
        chk("zero_busy_end", int'(busy), 0);

        // abort during WAIT of the third cell
        set_gin(2, 20, 100, 50);
        push(100, 50, 0, 0, 20); push(120, 50, 1, 0, 20); push(100, 70, 0, 1, 20);
        ack_limit = acks_given + 2;
        base = rq_seen;
        pulse_start();
        wait_req(base + 3, 200);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_draw_req", int'(draw_req), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_frame_done", int'(frame_done), 0);
        @(negedge clk); abort = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_stays_idle", int'(busy), 0);

        // settings change and stray start while busy
        set_gin(2, 10, 200, 300);
        ack_limit = acks_given + 100;
        push(200, 300, 0, 0, 10); push(210, 300, 1, 0, 10);
        push(200, 310, 0, 1, 10); push(210, 310, 1, 1, 10);
        exp_frames++;
        base = rq_seen;
        pulse_start();
        wait_req(base + 1, 50);
        gs.board_xpos = POS_W'(500);
        pulse_start();
        wait_idle(200);
        repeat (5) @(negedge clk);
        chk("t4_no_restart", int'(busy), 0);
        chk("t4_queue_empty", exp_q.size(), 0);
        chk("t4_frames", exp_frames, 0);

        // reset during WAIT, then a fresh sweep
        set_gin(2, 20, 0, 0);
        ack_limit = acks_given;
        push(0, 0, 0, 0, 20);
        base = rq_seen;
        pulse_start();
        wait_req(base + 1, 50);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_draw_req", int'(draw_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_xpos", int'(button_xpos), 0);
        chk("rst_ypos", int'(button_ypos), 0);
        chk("rst_size", int'(button_size), 0);
        chk("rst_col", int'(cell_col), 0);
        chk("rst_row", int'(cell_row), 0);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_needs_start", int'(busy), 0);
        ack_limit = acks_given + 100;
        push(0, 0, 0, 0, 20); push(20, 0, 1, 0, 20);
        push(0, 20, 0, 1, 20); push(20, 20, 1, 1, 20);
        exp_frames++;
        pulse_start();
        wait_idle(200);
        chk("t5_queue_empty", exp_q.size(), 0);

`ifdef BOARD_DRAW_TIMEOUT_EN
        // watchdog skips an unacknowledged cell 0 after 8 WAIT cycles
        set_gin(2, 20, 100, 50);
        ack_limit = acks_given;
        push(100, 50, 0, 0, 20); push(120, 50, 1, 0, 20);
        push(100, 70, 0, 1, 20); push(120, 70, 1, 1, 20);
        exp_frames++;
        base = rq_seen;
        pulse_start();
        wait_req(base + 1, 50);
        chk("wd_err_before", int'(timeout_err), 0);
        hi = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (!draw_req) break;
            hi++;
        end
        chk("wd_wait_cycles", hi, 8);
        ack_limit = acks_given + 100;
        wait_req(base + 2, 20);
        chk("wd_err_set", int'(timeout_err), 1);
        wait_idle(200);
        chk("wd_err_sticky", int'(timeout_err), 1);
        set_gin(0, 20, 100, 50);
        exp_frames++;
        pulse_start();
        chk("wd_err_cleared", int'(timeout_err), 0);
        wait_idle(20);
`endif

        repeat (3) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);
        chk("final_frames", exp_frames, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
